// File: rtl/shared_tlb_miss_handler_if.sv
// Bundles the lookup, page-table-walker, refill and fault signals of the shared TLB miss handler.
// The handler connects through the slave modport; the TLB/PTW environment uses the master modport.
interface shared_tlb_miss_handler_if #(
    parameter int VLEN       = 39,
    parameter int ASID_WIDTH = 16,
    parameter int PTE_WIDTH  = 64,
    parameter int CNT_WIDTH  = 32
);
    logic                   flush_i;
    logic                   lookup_valid_i;
    logic                   lookup_hit_i;
    logic [VLEN-1:0]        lookup_vaddr_i;
    logic                   lookup_is_itlb_i;
    logic [ASID_WIDTH-1:0]  asid_i;
    logic                   ptw_req_valid_o;
    logic                   ptw_req_ready_i;
    logic [VLEN-1:0]        ptw_req_vaddr_o;
    logic                   ptw_rsp_valid_i;
    logic                   ptw_rsp_error_i;
    logic [1:0]             ptw_rsp_level_i;
    logic [PTE_WIDTH-1:0]   ptw_rsp_pte_i;
    logic                   update_valid_o;
    logic [VLEN-13:0]       update_vpn_o;
    logic                   update_is_2M_o;
    logic                   update_is_1G_o;
    logic [ASID_WIDTH-1:0]  update_asid_o;
    logic [PTE_WIDTH-1:0]   update_pte_o;
    logic                   update_itlb_o;
    logic                   fault_valid_o;
    logic [VLEN-1:0]        fault_vaddr_o;
    logic                   fault_itlb_o;
    logic                   busy_o;
    logic [CNT_WIDTH-1:0]   miss_cnt_o;

    modport slave (
        input  flush_i, lookup_valid_i, lookup_hit_i, lookup_vaddr_i, lookup_is_itlb_i, asid_i,
        input  ptw_req_ready_i, ptw_rsp_valid_i, ptw_rsp_error_i, ptw_rsp_level_i, ptw_rsp_pte_i,
        output ptw_req_valid_o, ptw_req_vaddr_o,
        output update_valid_o, update_vpn_o, update_is_2M_o, update_is_1G_o, update_asid_o,
        output update_pte_o, update_itlb_o,
        output fault_valid_o, fault_vaddr_o, fault_itlb_o, busy_o, miss_cnt_o
    );

    modport master (
        output flush_i, lookup_valid_i, lookup_hit_i, lookup_vaddr_i, lookup_is_itlb_i, asid_i,
        output ptw_req_ready_i, ptw_rsp_valid_i, ptw_rsp_error_i, ptw_rsp_level_i, ptw_rsp_pte_i,
        input  ptw_req_valid_o, ptw_req_vaddr_o,
        input  update_valid_o, update_vpn_o, update_is_2M_o, update_is_1G_o, update_asid_o,
        input  update_pte_o, update_itlb_o,
        input  fault_valid_o, fault_vaddr_o, fault_itlb_o, busy_o, miss_cnt_o
    );
endinterface

// File: rtl/shared_tlb_miss_handler.sv
// Captures a shared-TLB miss, runs one page-table walk at a time and broadcasts the
// resulting refill (or page fault) to the shared TLB and the requesting L1 TLB.
module shared_tlb_miss_handler #(
    parameter int VLEN       = 39,
    parameter int ASID_WIDTH = 16,
    parameter int PTE_WIDTH  = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    shared_tlb_miss_handler_if.slave  bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] RSP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  missCnt_q, missCnt_d;
    logic [VLEN-1:0]       vaddr_q;
    logic                  isItlb_q;
    logic [ASID_WIDTH-1:0] asid_q;
    logic                  rspError_q;
    logic [1:0]            rspLevel_q;
    logic [PTE_WIDTH-1:0]  rspPte_q;
    logic                  miss;
    logic                  rspFault;

    assign miss     = bus.lookup_valid_i & ~bus.lookup_hit_i & (state_q == IDLE) & ~bus.flush_i;
    assign rspFault = rspError_q | (rspLevel_q == 2'd3);

    // A flush while the walker owns a request must still wait for its response (DRAIN),
    // unless that response arrives in the very same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss) state_d = REQ;
            REQ: begin
                if (bus.flush_i)              state_d = IDLE;
                else if (bus.ptw_req_ready_i) state_d = WAIT;
            end
            WAIT: begin
                if (bus.ptw_rsp_valid_i && bus.flush_i) state_d = IDLE;
                else if (bus.ptw_rsp_valid_i)           state_d = RSP;
                else if (bus.flush_i)                   state_d = DRAIN;
            end
            DRAIN:   if (bus.ptw_rsp_valid_i) state_d = IDLE;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        missCnt_d = missCnt_q;
        if (miss && !(&missCnt_q)) begin
            missCnt_d = missCnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            missCnt_q  <= '0;
            vaddr_q    <= '0;
            isItlb_q   <= 1'b0;
            asid_q     <= '0;
            rspError_q <= 1'b0;
            rspLevel_q <= 2'd0;
            rspPte_q   <= '0;
        end else begin
            state_q   <= state_d;
            missCnt_q <= missCnt_d;
            if (miss) begin
                vaddr_q  <= bus.lookup_vaddr_i;
                isItlb_q <= bus.lookup_is_itlb_i;
                asid_q   <= bus.asid_i;
            end
            if (state_q == WAIT && bus.ptw_rsp_valid_i && !bus.flush_i) begin
                rspError_q <= bus.ptw_rsp_error_i;
                rspLevel_q <= bus.ptw_rsp_level_i;
                rspPte_q   <= bus.ptw_rsp_pte_i;
            end
        end
    end

    // Payloads are forced to zero outside their pulse so downstream never sees stale data.
    always_comb begin
        bus.ptw_req_valid_o = 1'b0;
        bus.ptw_req_vaddr_o = '0;
        bus.update_valid_o  = 1'b0;
        bus.update_vpn_o    = '0;
        bus.update_is_2M_o  = 1'b0;
        bus.update_is_1G_o  = 1'b0;
        bus.update_asid_o   = '0;
        bus.update_pte_o    = '0;
        bus.update_itlb_o   = 1'b0;
        bus.fault_valid_o   = 1'b0;
        bus.fault_vaddr_o   = '0;
        bus.fault_itlb_o    = 1'b0;
        if (state_q == REQ) begin
            bus.ptw_req_valid_o = 1'b1;
            bus.ptw_req_vaddr_o = vaddr_q;
        end
        if (state_q == RSP) begin
            if (rspFault) begin
                bus.fault_valid_o = 1'b1;
                bus.fault_vaddr_o = vaddr_q;
                bus.fault_itlb_o  = isItlb_q;
            end else begin
                bus.update_valid_o = 1'b1;
                bus.update_vpn_o   = vaddr_q[VLEN-1:12];
                bus.update_is_2M_o = (rspLevel_q == 2'd1);
                bus.update_is_1G_o = (rspLevel_q == 2'd2);
                bus.update_asid_o  = asid_q;
                bus.update_pte_o   = rspPte_q;
                bus.update_itlb_o  = isItlb_q;
            end
        end
    end

    assign bus.busy_o     = (state_q != IDLE);
    assign bus.miss_cnt_o = missCnt_q;

endmodule

// File: tb/tb_shared_tlb_miss_handler.sv
// Directed self-checking bench for the shared TLB miss handler; a narrow miss counter
// keeps the saturation case reachable in a short run.
module tb_shared_tlb_miss_handler;

    localparam int VLEN = 39;
    localparam int ASID_WIDTH = 16;
    localparam int PTE_WIDTH = 64;
    localparam int CNT_WIDTH = 4;

    logic clk;
    logic rstN;
    int   checkCount = 0;
    int   passCount = 0;
    logic [CNT_WIDTH-1:0] expCnt = '0;

    shared_tlb_miss_handler_if #(
        .VLEN(VLEN), .ASID_WIDTH(ASID_WIDTH), .PTE_WIDTH(PTE_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) tbIf ();

    shared_tlb_miss_handler #(
        .VLEN(VLEN), .ASID_WIDTH(ASID_WIDTH), .PTE_WIDTH(PTE_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rstN),
        .bus    (tbIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of lookup traffic; leaves the lookup idle afterwards.
    task automatic applyStimulus(input logic hit, input logic [VLEN-1:0] vaddr,
                                 input logic itlb, input logic [ASID_WIDTH-1:0] asid);
        tbIf.lookup_valid_i   = 1'b1;
        tbIf.lookup_hit_i     = hit;
        tbIf.lookup_vaddr_i   = vaddr;
        tbIf.lookup_is_itlb_i = itlb;
        tbIf.asid_i           = asid;
        tick();
        tbIf.lookup_valid_i   = 1'b0;
        tbIf.lookup_hit_i     = 1'b0;
    endtask

    // From REQ: handshake, one idle WAIT cycle, response; returns in the RSP cycle.
    task automatic finishWalk(input logic err, input logic [1:0] lvl, input logic [PTE_WIDTH-1:0] pte);
        tbIf.ptw_req_ready_i = 1'b1;
        tick();
        tbIf.ptw_req_ready_i = 1'b0;
        tick();
        tbIf.ptw_rsp_valid_i = 1'b1;
        tbIf.ptw_rsp_error_i = err;
        tbIf.ptw_rsp_level_i = lvl;
        tbIf.ptw_rsp_pte_i   = pte;
        tick();
        tbIf.ptw_rsp_valid_i = 1'b0;
        tbIf.ptw_rsp_error_i = 1'b0;
        tbIf.ptw_rsp_level_i = 2'd0;
        tbIf.ptw_rsp_pte_i   = '0;
    endtask

    task automatic acceptMiss(input logic [VLEN-1:0] vaddr, input logic itlb, input logic [ASID_WIDTH-1:0] asid);
        applyStimulus(1'b0, vaddr, itlb, asid);
        if (expCnt != {CNT_WIDTH{1'b1}}) expCnt = expCnt + 1'b1;
    endtask

    initial begin
        logic [VLEN-1:0] heldVaddr;
        rstN = 1'b0;
        tbIf.flush_i = 1'b0;
        tbIf.lookup_valid_i = 1'b0;
        tbIf.lookup_hit_i = 1'b0;
        tbIf.lookup_vaddr_i = '0;
        tbIf.lookup_is_itlb_i = 1'b0;
        tbIf.asid_i = '0;
        tbIf.ptw_req_ready_i = 1'b0;
        tbIf.ptw_rsp_valid_i = 1'b0;
        tbIf.ptw_rsp_error_i = 1'b0;
        tbIf.ptw_rsp_level_i = 2'd0;
        tbIf.ptw_rsp_pte_i = '0;
        repeat (3) tick();
        checkOutput("rst_busy", tbIf.busy_o, 0);
        checkOutput("rst_req_valid", tbIf.ptw_req_valid_o, 0);
        checkOutput("rst_update_valid", tbIf.update_valid_o, 0);
        checkOutput("rst_fault_valid", tbIf.fault_valid_o, 0);
        checkOutput("rst_miss_cnt", tbIf.miss_cnt_o, 0);
        checkOutput("rst_vpn", tbIf.update_vpn_o, 0);
        rstN = 1'b1;
        tick();

        // Basic 4K walk
        acceptMiss(39'h12_3456_7000, 1'b1, 16'd5);
        checkOutput("t1_req_valid", tbIf.ptw_req_valid_o, 1);
        checkOutput("t1_req_vaddr", tbIf.ptw_req_vaddr_o, 64'h12_3456_7000);
        checkOutput("t1_busy", tbIf.busy_o, 1);
        checkOutput("t1_miss_cnt", tbIf.miss_cnt_o, 1);
        finishWalk(1'b0, 2'd0, 64'hCF);
        checkOutput("t1_update_valid", tbIf.update_valid_o, 1);
        checkOutput("t1_vpn", tbIf.update_vpn_o, 64'h1234567);
        checkOutput("t1_itlb", tbIf.update_itlb_o, 1);
        checkOutput("t1_asid", tbIf.update_asid_o, 5);
        checkOutput("t1_is_2M", tbIf.update_is_2M_o, 0);
        checkOutput("t1_is_1G", tbIf.update_is_1G_o, 0);
        checkOutput("t1_pte", tbIf.update_pte_o, 64'hCF);
        checkOutput("t1_no_fault", tbIf.fault_valid_o, 0);
        checkOutput("t1_busy_rsp", tbIf.busy_o, 1);
        tick();
        checkOutput("t1_update_drop", tbIf.update_valid_o, 0);
        checkOutput("t1_pte_zero", tbIf.update_pte_o, 0);
        checkOutput("t1_busy_idle", tbIf.busy_o, 0);

        // Hit lookup is ignored
        applyStimulus(1'b1, 39'h00_0000_1000, 1'b0, 16'd1);
        checkOutput("hit_req_valid", tbIf.ptw_req_valid_o, 0);
        checkOutput("hit_busy", tbIf.busy_o, 0);
        checkOutput("hit_miss_cnt", tbIf.miss_cnt_o, 1);

        // Back-to-back misses, 1G leaf
        acceptMiss(39'h40_0000_0000, 1'b0, 16'd7);
        applyStimulus(1'b0, 39'h55_5555_5000, 1'b1, 16'd9);
        checkOutput("b2b_req_vaddr", tbIf.ptw_req_vaddr_o, 64'h40_0000_0000);
        checkOutput("b2b_miss_cnt", tbIf.miss_cnt_o, 2);
        checkOutput("b2b_busy", tbIf.busy_o, 1);
        finishWalk(1'b0, 2'd2, 64'h1234);
        checkOutput("b2b_update_valid", tbIf.update_valid_o, 1);
        checkOutput("b2b_is_1G", tbIf.update_is_1G_o, 1);
        checkOutput("b2b_is_2M", tbIf.update_is_2M_o, 0);
        checkOutput("b2b_vpn", tbIf.update_vpn_o, 64'h4000000);
        checkOutput("b2b_itlb", tbIf.update_itlb_o, 0);
        tick();
        checkOutput("b2b_idle", tbIf.busy_o, 0);

        // 2M leaf
        acceptMiss(39'h01_0020_0000, 1'b0, 16'd3);
        finishWalk(1'b0, 2'd1, 64'h77);
        checkOutput("l1_is_2M", tbIf.update_is_2M_o, 1);
        checkOutput("l1_is_1G", tbIf.update_is_1G_o, 0);
        tick();

        // Error response
        acceptMiss(39'h7F_FFFF_F000, 1'b1, 16'd2);
        finishWalk(1'b1, 2'd0, 64'hFF);
        checkOutput("err_fault_valid", tbIf.fault_valid_o, 1);
        checkOutput("err_fault_vaddr", tbIf.fault_vaddr_o, 64'h7F_FFFF_F000);
        checkOutput("err_fault_itlb", tbIf.fault_itlb_o, 1);
        checkOutput("err_no_update", tbIf.update_valid_o, 0);
        tick();
        checkOutput("err_fault_drop", tbIf.fault_valid_o, 0);

        // Illegal level 3
        acceptMiss(39'h00_ABCD_E000, 1'b0, 16'd4);
        finishWalk(1'b0, 2'd3, 64'h11);
        checkOutput("lvl3_fault_valid", tbIf.fault_valid_o, 1);
        checkOutput("lvl3_fault_vaddr", tbIf.fault_vaddr_o, 64'h00_ABCD_E000);
        checkOutput("lvl3_no_update", tbIf.update_valid_o, 0);
        tick();

        // Flush in REQ beats ready
        acceptMiss(39'h00_1111_1000, 1'b0, 16'd6);
        tbIf.flush_i = 1'b1;
        tbIf.ptw_req_ready_i = 1'b1;
        tick();
        tbIf.flush_i = 1'b0;
        tbIf.ptw_req_ready_i = 1'b0;
        checkOutput("flreq_req_valid", tbIf.ptw_req_valid_o, 0);
        checkOutput("flreq_busy", tbIf.busy_o, 0);
        checkOutput("flreq_miss_cnt", tbIf.miss_cnt_o, {60'd0, expCnt});

        // Flush in WAIT drains the response
        acceptMiss(39'h00_2222_2000, 1'b0, 16'd6);
        tbIf.ptw_req_ready_i = 1'b1;
        tick();
        tbIf.ptw_req_ready_i = 1'b0;
        tbIf.flush_i = 1'b1;
        tick();
        tbIf.flush_i = 1'b0;
        checkOutput("flwait_busy_drain", tbIf.busy_o, 1);
        checkOutput("flwait_req_valid", tbIf.ptw_req_valid_o, 0);
        tbIf.ptw_rsp_valid_i = 1'b1;
        tbIf.ptw_rsp_pte_i = 64'hAB;
        tick();
        tbIf.ptw_rsp_valid_i = 1'b0;
        tbIf.ptw_rsp_pte_i = '0;
        checkOutput("flwait_no_update", tbIf.update_valid_o, 0);
        checkOutput("flwait_no_fault", tbIf.fault_valid_o, 0);
        checkOutput("flwait_idle", tbIf.busy_o, 0);
        tick();
        checkOutput("flwait_no_update2", tbIf.update_valid_o, 0);

        // Flush and response together in WAIT
        acceptMiss(39'h00_3333_3000, 1'b0, 16'd6);
        tbIf.ptw_req_ready_i = 1'b1;
        tick();
        tbIf.ptw_req_ready_i = 1'b0;
        tbIf.flush_i = 1'b1;
        tbIf.ptw_rsp_valid_i = 1'b1;
        tick();
        tbIf.flush_i = 1'b0;
        tbIf.ptw_rsp_valid_i = 1'b0;
        checkOutput("flrsp_idle", tbIf.busy_o, 0);
        checkOutput("flrsp_no_update", tbIf.update_valid_o, 0);
        checkOutput("flrsp_no_fault", tbIf.fault_valid_o, 0);

        // Ready held low for 10 cycles
        heldVaddr = 39'h0C_0FFE_E000;
        acceptMiss(heldVaddr, 1'b1, 16'h00AA);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_req_valid", tbIf.ptw_req_valid_o, 1);
            checkOutput("stall_req_vaddr", tbIf.ptw_req_vaddr_o, {25'd0, heldVaddr});
            tick();
        end
        finishWalk(1'b0, 2'd0, 64'h5A);
        checkOutput("stall_update_valid", tbIf.update_valid_o, 1);
        checkOutput("stall_asid", tbIf.update_asid_o, 16'h00AA);
        checkOutput("stall_miss_cnt", tbIf.miss_cnt_o, 9);
        tick();

        // Asynchronous reset mid-walk
        acceptMiss(39'h00_4444_4000, 1'b0, 16'd1);
        checkOutput("arst_busy_before", tbIf.busy_o, 1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("arst_busy", tbIf.busy_o, 0);
        checkOutput("arst_req_valid", tbIf.ptw_req_valid_o, 0);
        checkOutput("arst_miss_cnt", tbIf.miss_cnt_o, 0);
        expCnt = '0;
        tick();
        rstN = 1'b1;
        tick();

        // Counter saturation
        for (int i = 0; i < 16; i++) begin
            acceptMiss(39'h00_0001_0000 + 39'(i) * 39'h1000, 1'b0, 16'd8);
            finishWalk(1'b0, 2'd0, 64'h1);
            tick();
        end
        checkOutput("sat_miss_cnt", tbIf.miss_cnt_o, 64'hF);
        acceptMiss(39'h00_0002_0000, 1'b0, 16'd8);
        checkOutput("sat_miss_cnt_hold", tbIf.miss_cnt_o, 64'hF);
        checkOutput("sat_req_valid", tbIf.ptw_req_valid_o, 1);
        finishWalk(1'b0, 2'd0, 64'h2);
        checkOutput("sat_update_valid", tbIf.update_valid_o, 1);
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
